// File: rtl/fetch_pkg.sv
// fetch_pkg - shared types and constants for the MIPS32 instruction-fetch stage.
// Used by fetch_stage and fetch_buffer.
package fetch_pkg;

    // Fetch controller states.
    // IDLE: one cycle after reset, then REQ.
    // REQ:  normal fetching.
    // KILL: waiting for the ack of a request that a redirect discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; the low two bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer - single-entry holding register between instruction memory and IF/ID.
// Invalidate beats load beats consume.
// A load on the same edge as a consume keeps the entry valid with the new data.
import fetch_pkg::*;

module fetch_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic        invalidate_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Occupancy flag: cleared by a redirect or by IF/ID taking the entry, set by a new response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: clocked state uses non-blocking <= so every flop samples pre-edge values.
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (invalidate_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload capture on each accepted response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: this single entry is reset so that IF/ID sees a NOP with PC+4 = 4 out of reset.
        // A deeper RAM-style store would normally not be reset.
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0000_0000;
        end else if (load_i && !invalidate_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage - MIPS32 instruction-fetch stage feeding the IF/ID register.
// Owns the PC, talks req/ack to instruction memory, buffers one instruction,
// and handles stalls and branch/jump redirects (killing in-flight fetches).
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise o_instr_cnt and o_kill_cnt are tied to zero.
import fetch_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DATA_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_a_rst,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [DATA_W-1:0] i_redirect_pc,
    output logic              o_imem_req,
    output logic [DATA_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [DATA_W-1:0] o_instr_fetch,
    output logic [DATA_W-1:0] o_PC_4_fetch,
    output logic              o_dec_we,
    output logic              o_dec_s_rst,
    output logic [DATA_W-1:0] o_instr_cnt,
    output logic [DATA_W-1:0] o_kill_cnt
);

    fetch_state_e      state_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] req_addr_q;
    logic [DATA_W-1:0] redirect_tgt;

    logic              buf_valid;
    logic [DATA_W-1:0] buf_instr;
    logic [DATA_W-1:0] buf_pc;

    logic              dec_we;
    logic              imem_req;
    logic              ack;
    logic              buf_load;

    assign redirect_tgt = word_align(i_redirect_pc);

    // Handshake and IF/ID write-enable from current state and buffer occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        dec_we   = buf_valid & ~i_stall & ~i_redirect;
        imem_req = 1'b0;
        case (state_q)
            // A new request goes out only if the buffer will have room at the next edge.
            REQ:     imem_req = ~buf_valid | dec_we;
            KILL:    imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
        ack      = imem_req & i_imem_ack;
        buf_load = (state_q == REQ) & ack & ~i_redirect;
    end

    // Fetch controller: PC, request address and the kill sequencing.
    // req_addr only changes when no request is pending.
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    if (i_redirect) begin
                        pc_q       <= redirect_tgt;
                        req_addr_q <= redirect_tgt;
                    end
                end
                REQ: begin
                    if (i_redirect) begin
                        pc_q <= redirect_tgt;
                        if (imem_req && !i_imem_ack) begin
                            // The pending request must still finish at its old address.
                            state_q <= KILL;
                        end else begin
                            req_addr_q <= redirect_tgt;
                        end
                    end else if (ack) begin
                        pc_q       <= pc_q + PC_STEP;
                        req_addr_q <= pc_q + PC_STEP;
                    end
                end
                KILL: begin
                    if (i_redirect) begin
                        pc_q <= redirect_tgt;
                    end
                    if (ack) begin
                        state_q    <= REQ;
                        req_addr_q <= i_redirect ? redirect_tgt : pc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_buffer u_buffer (
        .clk_i        (i_clk),
        .rst_i        (i_a_rst),
        .load_i       (buf_load),
        .consume_i    (dec_we),
        .invalidate_i (i_redirect),
        .instr_i      (i_imem_rdata),
        .pc_i         (req_addr_q),
        .valid_o      (buf_valid),
        .instr_o      (buf_instr),
        .pc_o         (buf_pc)
    );

    assign o_imem_req    = imem_req;
    assign o_imem_addr   = req_addr_q;
    assign o_instr_fetch = buf_instr;
    assign o_PC_4_fetch  = buf_pc + PC_STEP;
    assign o_dec_we      = dec_we;
    assign o_dec_s_rst   = i_redirect;

`ifdef FETCH_PERF_CNT_EN
    logic              dropped;
    logic [DATA_W-1:0] instr_cnt_q;
    logic [DATA_W-1:0] kill_cnt_q;

    // A response is dropped when a kill completes or when a redirect lands with the ack.
    assign dropped = ack & ((state_q == KILL) | i_redirect);

    // Count IF/ID writes and discarded responses; both wrap naturally.
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            instr_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (dec_we) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
            if (dropped) begin
                kill_cnt_q <= kill_cnt_q + 1'b1;
            end
        end
    end

    assign o_instr_cnt = instr_cnt_q;
    assign o_kill_cnt  = kill_cnt_q;
`else
    assign o_instr_cnt = '0;
    assign o_kill_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage - directed, self-checking bench for fetch_stage.
// A queue holds the PCs expected to reach IF/ID, in order.
// Each o_dec_we pulse pops the queue and checks the instruction and PC+4.
// The memory model acks after a programmable delay and can be throttled by an ack budget.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_fetch;
    logic [31:0] pc4_fetch;
    logic        dec_we;
    logic        dec_s_rst;
    logic [31:0] instr_cnt;
    logic [31:0] kill_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc = 32'h0;

    // Memory model controls
    int          ack_delay = 0;
    bit          ack_inf   = 1'b1;
    int          ack_grant = 0;
    int          ack_used  = 0;
    int          wait_cnt  = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_a_rst       (rst),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr_fetch (instr_fetch),
        .o_PC_4_fetch  (pc4_fetch),
        .o_dec_we      (dec_we),
        .o_dec_s_rst   (dec_s_rst),
        .o_instr_cnt   (instr_cnt),
        .o_kill_cnt    (kill_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: distinct word per address, 32'h2008_0005 at address 0.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2008_0005 ^ {a[15:0], 16'h0000};
    endfunction

    assign imem_ack   = imem_req && (ack_inf || (ack_used < ack_grant)) && (wait_cnt >= ack_delay);
    assign imem_rdata = mem_word(imem_addr);

    // Wait-state counter for the current request.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 0;
        end else if (!imem_req || imem_ack) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // Count acks handed out, so the budget can be enforced.
    always @(posedge clk) begin
        if (imem_ack) begin
            ack_used <= ack_used + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Replace the expected write stream with n sequential PCs from start.
    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endtask

    // Move to the falling edge and score any IF/ID write of this cycle.
    task automatic settle();
        logic [31:0] e;
        @(negedge clk);
        if (!rst && dec_we) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_extra_write: observed write pc4=%h expected no write", pc4_fetch);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_pc4", pc4_fetch, e + 32'd4);
                check("sb_instr", instr_fetch, mem_word(e));
                last_pc = e;
            end
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            check_bit("no_flush", dec_s_rst, 1'b0);
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_req"}, imem_req, 1'b0);
        check_bit({tag, "_we"}, dec_we, 1'b0);
        check_bit({tag, "_srst"}, dec_s_rst, 1'b0);
        check({tag, "_instr"}, instr_fetch, 32'h0);
        check({tag, "_pc4"}, pc4_fetch, 32'd4);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_icnt"}, instr_cnt, 32'h0);
        check({tag, "_kcnt"}, kill_cnt, 32'h0);
    endtask

    initial begin
        logic        found;
        logic [31:0] held;
        logic [31:0] old_addr;

        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        ack_delay   = 0;
        ack_inf     = 1'b1;
        push_seq(32'h0, 64);

        // Reset values
        settle();
        check_reset_outputs("rst");
        tick();
        rst = 1'b0;

        // Streaming from address 0, ack tied to req
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (imem_req) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_bit("first_req_seen", found, 1'b1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        run(5);

        // Stall with a full buffer for three cycles
        stall = 1'b1;
        settle();
        check_bit("stall_we", dec_we, 1'b0);
        check_bit("stall_req", imem_req, 1'b0);
        held = instr_fetch;
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            check_bit("stall_we", dec_we, 1'b0);
            check_bit("stall_req", imem_req, 1'b0);
            check("stall_instr_hold", instr_fetch, held);
        end
        ack_delay = 4;
        tick();
        stall = 1'b0;
        settle();
        check_bit("resume_we", dec_we, 1'b1);
        check("resume_instr", instr_fetch, held);
        check_bit("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, last_pc + 32'd4);
        old_addr = last_pc + 32'd4;
        tick();
        settle();
        check_bit("pend_req", imem_req, 1'b1);
        check_bit("pend_we", dec_we, 1'b0);

        // Redirect to 0x403 while the ack is still delayed
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0403;
        push_seq(32'h0000_0400, 64);
        settle();
        check_bit("redir_srst", dec_s_rst, 1'b1);
        check_bit("redir_we", dec_we, 1'b0);
        check("redir_addr_hold", imem_addr, old_addr);
        tick();
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_bit("kill_req", imem_req, 1'b1);
            check("kill_addr_hold", imem_addr, old_addr);
            check_bit("kill_srst", dec_s_rst, 1'b0);
            if (imem_ack) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_bit("kill_ack_seen", found, 1'b1);
        tick();
        settle();
        check_bit("post_kill_req", imem_req, 1'b1);
        check("post_kill_addr", imem_addr, 32'h0000_0400);
        tick();
        run(12);

        // Redirect coinciding with ack and stall
        ack_inf   = 1'b0;
        ack_grant = ack_used;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (imem_req && !dec_we) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_bit("coinc_req_seen", found, 1'b1);
        tick();
        ack_delay   = 0;
        ack_grant   = ack_used + 1;
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        push_seq(32'h0000_0400, 64);
        settle();
        check_bit("coinc_ack", imem_ack, 1'b1);
        check_bit("coinc_srst", dec_s_rst, 1'b1);
        check_bit("coinc_we", dec_we, 1'b0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        settle();
        check_bit("coinc_next_req", imem_req, 1'b1);
        check("coinc_next_addr", imem_addr, 32'h0000_0400);
        check_bit("coinc_dropped", dec_we, 1'b0);
        tick();
        ack_inf = 1'b1;
        run(6);

        // PC wrap at 32'hFFFF_FFFC
        stall = 1'b1;
        settle();
        check_bit("wrap_stall_req", imem_req, 1'b0);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_seq(32'hFFFF_FFFC, 64);
        settle();
        check_bit("wrap_srst", dec_s_rst, 1'b1);
        check_bit("wrap_redir_we", dec_we, 1'b0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        settle();
        check_bit("wrap_req", imem_req, 1'b1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        settle();
        check_bit("wrap_we", dec_we, 1'b1);
        check("wrap_pc4", pc4_fetch, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        tick();
        run(4);

        // Reset mid-stream, then 10 instructions and one killed fetch
        ack_inf   = 1'b0;
        ack_grant = ack_used;
        rst       = 1'b1;
        exp_q.delete();
        settle();
        check_reset_outputs("rst2");
        tick();
        ack_grant = ack_used + 10;
        push_seq(32'h0, 10);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if ((ack_used == ack_grant) && imem_req && !dec_we) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_bit("cnt_ten_acks", found, 1'b1);
        check("cnt_all_written", 32'(exp_q.size()), 32'd0);
        check("cnt_pending_addr", imem_addr, 32'd40);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0800;
        settle();
        check_bit("cnt_redir_srst", dec_s_rst, 1'b1);
        tick();
        redirect  = 1'b0;
        ack_grant = ack_used + 1;
        settle();
        check_bit("cnt_kill_ack", imem_ack, 1'b1);
        check("cnt_kill_addr", imem_addr, 32'd40);
        tick();
        run(3);
        settle();
        check_bit("cnt_final_req", imem_req, 1'b1);
        check("cnt_final_addr", imem_addr, 32'h0000_0800);
`ifdef FETCH_PERF_CNT_EN
        check("instr_cnt", instr_cnt, 32'd10);
        check("kill_cnt", kill_cnt, 32'd1);
`else
        check("instr_cnt_off", instr_cnt, 32'd0);
        check("kill_cnt_off", kill_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
